pipe_skid_reg: RTL and testbench

Parametrised elastic pipeline register for the pipelined CPU. It replaces the fixed-field, write-enable-gated stage latches with a generic valid/ready stage that has a two-entry skid buffer, a synchronous flush that inserts a bubble, and a saturating bubble counter. It sits between any two pipeline stages: IF/ID, ID/EX, EX/MEM and MEM/WB each become one instance, with the stage's control and data fields packed into `in_data`.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_skid_reg.sv | 113 +++++++++++
 tb/tb_pipe_skid_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: per-stage payload bundles and their widths,
// plus the elastic-stage occupancy names used by pipe_skid_reg.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, updated on the falling clock edge; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer, bubble-inserting
// flush and a saturating bubble counter. All state moves on the falling edge of CLK.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             accept;
  logic             drain;
  stage_state_e     state;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  assign accept = in_valid & !skid_v_q;
  assign drain  = main_v_q & out_ready;

  always_comb begin
    state = EMPTY;
    if (skid_v_q) begin
      state = FULL;
    end else if (main_v_q) begin
      state = BUSY;
    end
  end

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (FLUSH) begin
      // A same-cycle drain still hands out the current main entry downstream.
      main_d   = '0;
      skid_d   = '0;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_d   = in_data;
            main_v_d = 1'b1;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
          end else if (drain) begin
            main_v_d = 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk(CLK),
    .rst(RST),
    .inc(out_ready & !main_v_q),
    .clr(cnt_clr),
    .q  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg (WIDTH=32, CNT_W=3): reset, streaming,
// back-pressure, flush cases and bubble-counter saturation/clear.
module tb_pipe_skid_reg;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        cnt_clr;
  logic [2:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(
    .WIDTH(32),
    .CNT_W(3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next falling (active) edge and settle.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RST       = 1'b1;
    FLUSH     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    tick();
    RST = 1'b0;

    // Streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    chk("stream1_valid", 64'(out_valid), 64'd1);
    chk("stream1_data", 64'(out_data), 64'h11);
    chk("stream1_in_ready", 64'(in_ready), 64'd1);
    in_data = 32'h22;
    tick();
    chk("stream2_data", 64'(out_data), 64'h22);
    chk("stream2_in_ready", 64'(in_ready), 64'd1);
    in_data = 32'h33;
    tick();
    chk("stream3_data", 64'(out_data), 64'h33);
    chk("stream3_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("stream_done_valid", 64'(out_valid), 64'd0);

    // Back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    tick();
    chk("bp1_data", 64'(out_data), 64'hA1);
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    in_data = 32'hA2;
    tick();
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_full_data", 64'(out_data), 64'hA1);
    chk("bp_full_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_data", 64'(out_data), 64'hA1);
    chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_data", 64'(out_data), 64'hA2);
    chk("bp_drain1_valid", 64'(out_valid), 64'd1);
    chk("bp_drain1_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_drain2_valid", 64'(out_valid), 64'd0);

    // Flush while FULL, with a beat offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    chk("fl_full_in_ready", 64'(in_ready), 64'd0);
    FLUSH   = 1'b1;
    in_data = 32'hBB;
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_data_cleared", 64'(out_data), 64'd0);
    FLUSH     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_no_bb_valid", 64'(out_valid), 64'd0);
    chk("fl_no_bb_data", 64'(out_data), 64'd0);

    // Flush with simultaneous drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC1;
    tick();
    in_valid = 1'b0;
    chk("fd_pre_valid", 64'(out_valid), 64'd1);
    chk("fd_pre_data", 64'(out_data), 64'hC1);
    out_ready = 1'b1;
    FLUSH     = 1'b1;
    #1;
    chk("fd_delivered", 64'({out_valid, out_ready, out_data}), {30'd0, 2'b11, 32'hC1});
    tick();
    FLUSH = 1'b0;
    chk("fd_after_valid", 64'(out_valid), 64'd0);
    chk("fd_after_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD1;
    tick();
    in_data = 32'hD2;
    tick();
    in_valid = 1'b0;
    chk("ar_full_in_ready", 64'(in_ready), 64'd0);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_out_data", 64'(out_data), 64'd0);
    chk("ar_bubble_cnt", 64'(bubble_cnt), 64'd0);
    tick();
    RST = 1'b0;

    // Bubble counter saturation and clear priority
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bc_three", 64'(bubble_cnt), 64'd3);
    for (int i = 0; i < 7; i++) tick();
    chk("bc_saturated", 64'(bubble_cnt), 64'd7);
    cnt_clr = 1'b1;
    tick();
    chk("bc_clear", 64'(bubble_cnt), 64'd0);
    cnt_clr = 1'b0;
    tick();
    chk("bc_restart", 64'(bubble_cnt), 64'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("bc_flush_counts", 64'(bubble_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
